// File: rtl/axi4_str_sink_if.sv
// axi4_str_sink_if: AXI4-Stream data/valid/ready bundle
interface axi4_str_sink_if #(parameter int DATA_WDTH = 8);
  logic [DATA_WDTH-1:0] tdata;
  logic                 tvalid;
  logic                 tready;
  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axi4_str_sink.sv
// axi4_str_sink: AXIS sink checking an incrementing sequence; optional AXI4_STR_SINK_THROTTLE_EN LFSR ready throttle
module axi4_str_sink #(
  parameter int          DATA_WDTH = 8,
  parameter int          CNT_WDTH  = 16,
  parameter int          ERR_WDTH  = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                 s_axis_clk,
  input  logic                 s_axis_areset,
  axi4_str_sink_if.slave       s_axis,
  input  logic                 clr,
  output logic                 synced,
  output logic [CNT_WDTH-1:0]  beat_cnt,
  output logic [ERR_WDTH-1:0]  err_cnt,
  output logic                 err_flag,
  output logic [DATA_WDTH-1:0] first_err_exp,
  output logic [DATA_WDTH-1:0] first_err_got
);
  typedef enum logic {SYNC, TRACK} state_t;
  state_t               r_state;
  logic                 r_synced;
  logic                 r_tready;
  logic [CNT_WDTH-1:0]  r_beat_cnt;
  logic [ERR_WDTH-1:0]  r_err_cnt;
  logic                 r_err_flag;
  logic [DATA_WDTH-1:0] r_first_exp;
  logic [DATA_WDTH-1:0] r_first_got;
  logic [DATA_WDTH-1:0] r_exp;
  logic                 w_acc;
  logic                 w_tready_nxt;
  if (LFSR_SEED == 16'h0) begin : g_bad_seed
    $error("LFSR_SEED must be nonzero");
  end
`ifdef AXI4_STR_SINK_THROTTLE_EN
  logic [15:0] r_lfsr;
  // Fibonacci LFSR x^16+x^14+x^13+x^11+1, free-running outside reset and untouched by clr
  always_ff @(posedge s_axis_clk) begin
    if (s_axis_areset) r_lfsr <= LFSR_SEED;
    else r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  end
  assign w_tready_nxt = ~(r_lfsr[1] & r_lfsr[0]);
`else
  assign w_tready_nxt = 1'b1;
`endif
  assign w_acc         = s_axis.tvalid & r_tready;
  assign s_axis.tready = r_tready;
  assign synced        = r_synced;
  assign beat_cnt      = r_beat_cnt;
  assign err_cnt       = r_err_cnt;
  assign err_flag      = r_err_flag;
  assign first_err_exp = r_first_exp;
  assign first_err_got = r_first_got;
  // Sequence tracker FSM with statistics; clr wins over a beat in the same cycle
  always_ff @(posedge s_axis_clk) begin
    if (s_axis_areset) begin
      r_state     <= SYNC;
      r_synced    <= 1'b0;
      r_tready    <= 1'b0;
      r_beat_cnt  <= '0;
      r_err_cnt   <= '0;
      r_err_flag  <= 1'b0;
      r_first_exp <= '0;
      r_first_got <= '0;
      r_exp       <= '0;
    end else begin
      r_tready <= w_tready_nxt;
      if (clr) begin
        r_state     <= SYNC;
        r_synced    <= 1'b0;
        r_beat_cnt  <= '0;
        r_err_cnt   <= '0;
        r_err_flag  <= 1'b0;
        r_first_exp <= '0;
        r_first_got <= '0;
        r_exp       <= '0;
      end else if (w_acc) begin
        r_beat_cnt <= (&r_beat_cnt) ? r_beat_cnt : r_beat_cnt + 1'b1;
        if (r_state == SYNC) begin
          r_exp    <= s_axis.tdata + 1'b1;
          r_state  <= TRACK;
          r_synced <= 1'b1;
        end else if (s_axis.tdata == r_exp) begin
          r_exp <= r_exp + 1'b1;
        end else begin
          r_err_cnt  <= (&r_err_cnt) ? r_err_cnt : r_err_cnt + 1'b1;
          r_err_flag <= 1'b1;
          r_exp      <= s_axis.tdata + 1'b1;
          if (!r_err_flag) begin
            r_first_exp <= r_exp;
            r_first_got <= s_axis.tdata;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_axi4_str_sink.sv
// tb_axi4_str_sink: directed self-checking bench for axi4_str_sink
`define CHK(tag, obs, exp) \
  checks++; \
  assert ((obs) === (exp)) else begin \
    errors++; \
    $error("FAIL %s observed=%0h expected=%0h", tag, (obs), (exp)); \
  end

module tb_axi4_str_sink;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        synced;
  logic [15:0] beat_cnt;
  logic [7:0]  err_cnt;
  logic        err_flag;
  logic [7:0]  first_err_exp;
  logic [7:0]  first_err_got;
  int          checks = 0;
  int          errors = 0;
  logic        exp_rdy;

  axi4_str_sink_if #(.DATA_WDTH(8)) axis ();

  axi4_str_sink #(.DATA_WDTH(8), .CNT_WDTH(16), .ERR_WDTH(8), .LFSR_SEED(16'hACE1)) dut (
    .s_axis_clk    (clk),
    .s_axis_areset (rst),
    .s_axis        (axis.slave),
    .clr           (clr),
    .synced        (synced),
    .beat_cnt      (beat_cnt),
    .err_cnt       (err_cnt),
    .err_flag      (err_flag),
    .first_err_exp (first_err_exp),
    .first_err_got (first_err_got)
  );

  always #5 clk = ~clk;

`ifdef AXI4_STR_SINK_THROTTLE_EN
  logic [15:0] m_lfsr;
  logic        m_rdy;
  always @(posedge clk) begin
    if (rst) begin
      m_lfsr <= 16'hACE1;
      m_rdy  <= 1'b0;
    end else begin
      m_rdy  <= ~(m_lfsr[1] & m_lfsr[0]);
      m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end
  end
  assign exp_rdy = m_rdy;
  always @(negedge clk) begin
    `CHK("tready_vs_lfsr", axis.tready, m_rdy)
  end
`else
  assign exp_rdy = ~rst;
`endif

  task automatic send(input logic [7:0] d);
    int  n;
    logic r;
    axis.tvalid = 1'b1;
    axis.tdata  = d;
    for (n = 0; n < 64; n++) begin
      r = axis.tready;
      @(negedge clk);
      if (r) break;
    end
    if (n == 64) begin
      checks++;
      errors++;
      $error("FAIL send_timeout observed=%0d expected=<64", n);
    end
  endtask

  task automatic idle();
    axis.tvalid = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    axis.tvalid = 1'b0;
    axis.tdata  = 8'h00;
    repeat (5) @(negedge clk);
    `CHK("rst_tready", axis.tready, 1'b0)
    `CHK("rst_synced", synced, 1'b0)
    `CHK("rst_beat", beat_cnt, 16'h0)
    `CHK("rst_err", err_cnt, 8'h0)
    `CHK("rst_flag", err_flag, 1'b0)
    `CHK("rst_fexp", first_err_exp, 8'h0)
    `CHK("rst_fgot", first_err_got, 8'h0)
    rst = 1'b0;
    @(negedge clk);
    `CHK("tready_after_rst", axis.tready, exp_rdy)
    // 0x10..0x1F back to back
    for (int i = 0; i < 16; i++) send(8'(8'h10 + i));
    idle();
    `CHK("seq_beat", beat_cnt, 16'd16)
    `CHK("seq_err", err_cnt, 8'h0)
    `CHK("seq_flag", err_flag, 1'b0)
    `CHK("seq_synced", synced, 1'b1)
    // wrap-around
    pulse_clr();
    send(8'hFE); send(8'hFF); send(8'h00); send(8'h01);
    idle();
    `CHK("wrap_beat", beat_cnt, 16'd4)
    `CHK("wrap_err", err_cnt, 8'h0)
    `CHK("wrap_flag", err_flag, 1'b0)
    // mismatches with first-error capture
    pulse_clr();
    send(8'h20); send(8'h21); send(8'h30); send(8'h31); send(8'h40);
    idle();
    `CHK("mm_beat", beat_cnt, 16'd5)
    `CHK("mm_err", err_cnt, 8'd2)
    `CHK("mm_flag", err_flag, 1'b1)
    `CHK("mm_fexp", first_err_exp, 8'h22)
    `CHK("mm_fgot", first_err_got, 8'h30)
    // 300 mismatching beats saturate err_cnt
    for (int i = 0; i < 300; i++) send(8'h00);
    idle();
    `CHK("sat_err", err_cnt, 8'hFF)
    `CHK("sat_beat", beat_cnt, 16'd305)
    `CHK("sat_fexp", first_err_exp, 8'h22)
    `CHK("sat_fgot", first_err_got, 8'h30)
    // clr together with a valid beat
    while (!axis.tready) @(negedge clk);
    axis.tvalid = 1'b1;
    axis.tdata  = 8'h55;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    idle();
    `CHK("clr_beat", beat_cnt, 16'h0)
    `CHK("clr_err", err_cnt, 8'h0)
    `CHK("clr_flag", err_flag, 1'b0)
    `CHK("clr_fexp", first_err_exp, 8'h0)
    `CHK("clr_fgot", first_err_got, 8'h0)
    `CHK("clr_synced", synced, 1'b0)
    send(8'h77); send(8'h78);
    idle();
    `CHK("post_clr_beat", beat_cnt, 16'd2)
    `CHK("post_clr_err", err_cnt, 8'h0)
    `CHK("post_clr_synced", synced, 1'b1)
    // reset mid-stream discards the in-flight beat
    send(8'h79);
    axis.tvalid = 1'b1;
    axis.tdata  = 8'h90;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    axis.tvalid = 1'b0;
    `CHK("mid_rst_tready", axis.tready, 1'b0)
    `CHK("mid_rst_synced", synced, 1'b0)
    `CHK("mid_rst_beat", beat_cnt, 16'h0)
    `CHK("mid_rst_err", err_cnt, 8'h0)
    @(negedge clk);
    `CHK("mid_rst_tready_up", axis.tready, exp_rdy)
    send(8'h90);
    idle();
    `CHK("resync_synced", synced, 1'b1)
    `CHK("resync_beat", beat_cnt, 16'd1)
    `CHK("resync_err", err_cnt, 8'h0)
    send(8'h92);
    idle();
    `CHK("resync_mm_err", err_cnt, 8'd1)
    `CHK("resync_mm_fexp", first_err_exp, 8'h91)
    `CHK("resync_mm_fgot", first_err_got, 8'h92)
    // 100-beat stream with tvalid held high
    pulse_clr();
    for (int i = 0; i < 100; i++) send(8'(i));
    idle();
    `CHK("stream_beat", beat_cnt, 16'd100)
    `CHK("stream_err", err_cnt, 8'h0)
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi4_str_sink.md
AXI4_STR_SINK -- requirements
Module: axi4_str_sink

Interface
REQ-001 Parameter DATA_WDTH, default 8, sets the AXIS data width in bits.
REQ-002 Parameter CNT_WDTH, default 16, sets the beat-counter width.
REQ-003 Parameter ERR_WDTH, default 8, sets the error-counter width.
REQ-004 Parameter LFSR_SEED, default 16'hACE1, is the throttle LFSR reset value; a value of 0 is illegal.
REQ-005 s_axis_clk  input  1  is the single clock; all logic is on its rising edge.
REQ-006 s_axis_areset  input  1  is a synchronous, active-high reset.
REQ-007 s_axis_tdata  input  DATA_WDTH  is the slave AXIS data.
REQ-008 s_axis_tvalid  input  1  is the slave AXIS valid.
REQ-009 s_axis_tready  output  1  is the slave AXIS ready, driven from a register.
REQ-010 clr  input  1  is a single-cycle pulse that clears statistics and returns the block to SYNC.
REQ-011 synced  output  1  is high while the FSM is in TRACK.
REQ-012 beat_cnt  output  CNT_WDTH  is the count of accepted beats.
REQ-013 err_cnt  output  ERR_WDTH  is the count of sequence mismatches.
REQ-014 err_flag  output  1  is a sticky flag, set on the first mismatch.
REQ-015 first_err_exp / first_err_got  output  DATA_WDTH each  hold the expected and received data of the first mismatch.

Function
REQ-016 A beat is accepted in a cycle where s_axis_tvalid and s_axis_tready are both high; no other cycle changes state, except clr, reset and the LFSR advance.
REQ-017 The FSM has two states, SYNC and TRACK.
- SYNC: the first accepted beat loads exp = tdata+1 (modulo 2^DATA_WDTH) and moves to TRACK.
- TRACK: on each accepted beat, if tdata equals exp then exp = exp+1; otherwise it is a mismatch.
REQ-018 On a mismatch the block:
- increments err_cnt;
- sets err_flag;
- captures first_err_exp/got only if err_flag was 0 before that beat;
- resynchronises with exp = tdata+1 and stays in TRACK.
REQ-019 exp wraps from all-ones to 0 without a mismatch; for example, 8'hFF followed by 8'h00 is legal.
REQ-020 beat_cnt increments on every accepted beat, in either state, and saturates at all-ones.
REQ-021 err_cnt saturates at all-ones; err_flag remains set until clr or reset.
REQ-022 All statistics outputs update on the clock edge that accepts the beat, giving one cycle of latency from acceptance to visibility.
REQ-023 clr has priority over a beat accepted in the same cycle: that beat is discarded, not counted and not checked.
- clr zeroes beat_cnt, err_cnt, err_flag, first_err_exp/got and exp.
- clr forces SYNC.
- clr does not reset the LFSR.
REQ-024 s_axis_tready does not depend combinationally on s_axis_tvalid; a deasserted tready never drops a beat, because the upstream holds tvalid/tdata.

Reset
REQ-025 While s_axis_areset is high at a clock edge, the block sets:
- FSM = SYNC, synced = 0;
- beat_cnt = 0, err_cnt = 0, err_flag = 0;
- first_err_exp = 0, first_err_got = 0, exp = 0;
- LFSR = LFSR_SEED;
- s_axis_tready = 0.
REQ-026 s_axis_tready goes high, or follows the throttle, starting on the first edge after reset is released; a reset in the middle of a stream discards the in-flight beat.

Configuration
REQ-027 The macro AXI4_STR_SINK_THROTTLE_EN, when defined, compiles in a 16-bit Fibonacci LFSR.
- Polynomial: x^16+x^14+x^13+x^11+1.
- The LFSR shifts every cycle outside reset.
- The next s_axis_tready = ~(lfsr[1] & lfsr[0]), giving roughly 75% duty.
REQ-028 When AXI4_STR_SINK_THROTTLE_EN is undefined, no LFSR exists and s_axis_tready is a register that goes to 1 on the first edge after reset and then stays 1.

Verification
REQ-029 Reset for 5 cycles, then drive 0x10..0x1F on back-to-back valid beats -> beat_cnt=16, err_cnt=0, err_flag=0, synced=1.
REQ-030 Drive 0xFE, 0xFF, 0x00, 0x01 -> no mismatch; wrap-around is accepted; beat_cnt=4.
REQ-031 Drive 0x20, 0x21, 0x30, 0x31, 0x40 -> err_cnt=2, first_err_exp=0x22, first_err_got=0x30, err_flag=1.
REQ-032 After 300 mismatching beats -> err_cnt=0xFF (saturated); pulse clr together with a valid beat -> all statistics 0, synced=0, and the beat is not counted.
REQ-033 With AXI4_STR_SINK_THROTTLE_EN defined, tvalid held high with data 0x00..0x63 -> tready pattern matches the LFSR model; beat_cnt=100 after the last handshake; err_cnt=0; tdata is never sampled while tready=0.
REQ-034 Assert s_axis_areset for 1 cycle in the middle of a stream -> all outputs take their REQ-025 values on the next edge; the next accepted beat re-seeds from SYNC.
